array_port_arbiter: RTL

- Shares one single-port 256x16 storage array between two requesters (port 0, port 1), e.g. a pixel writer and a display/readout engine.
- Grants at most one access per cycle using round-robin priority and returns read data one cycle after the read is granted.
- Optionally runs a hardware clear sweep that fills every entry with a constant.
- Sits between the requesters and the memory; the memory is external to this block.

---
 rtl/array_port_arbiter_pkg.sv | 13 +
 rtl/array_port_arbiter_if.sv | 51 +++++
 rtl/array_port_arbiter_rr_arb2.sv | 18 +
 rtl/array_port_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/array_port_arbiter_pkg.sv
// rtl/array_port_arbiter_pkg.sv - shared defaults and sweep FSM state encoding for array_port_arbiter
package array_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] CLEAR_VAL_DEF = 16'h0000;

  // Sweep FSM states: IDLE arbitrates the ports, CLEAR owns the array.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/array_port_arbiter_if.sv
// rtl/array_port_arbiter_if.sv - requester, response and memory signals of array_port_arbiter
interface array_port_arbiter_if
  import array_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_index;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_index;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_index;
  logic [DATA_W-1:0] mem_wr_val;
  logic [DATA_W-1:0] mem_rd_val;

  logic              clear_start;
  logic              clear_busy;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_we, req0_index, req0_wdata,
    input  req1_valid, req1_we, req1_index, req1_wdata,
    input  mem_rd_val, clear_start,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    output mem_wr_en, mem_index, mem_wr_val, clear_busy
  );

  // Requesters plus memory side.
  modport master (
    output req0_valid, req0_we, req0_index, req0_wdata,
    output req1_valid, req1_we, req1_index, req1_wdata,
    output mem_rd_val, clear_start,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
    input  mem_wr_en, mem_index, mem_wr_val, clear_busy
  );

endinterface

// File: rtl/array_port_arbiter_rr_arb2.sv
// rtl/array_port_arbiter_rr_arb2.sv - two-request round-robin picker producing a one-hot grant
module rr_arb2
  import array_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // A lone requester always wins; a contended cycle goes to the port the pointer names.
  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/array_port_arbiter.sv
// rtl/array_port_arbiter.sv - round-robin sharing of one single-port array by two requesters; ARRAY_PORT_ARBITER_CLEAR_EN adds a clear sweep
module array_port_arbiter
  import array_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL = CLEAR_VAL_DEF
) (
  input logic                 clk,
  input logic                 rst,
  array_port_arbiter_if.slave bus
);

  logic [1:0] req_valid;
  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       arb_en;
  logic       ptr_q, ptr_d;
  logic       rsp0_q, rsp0_d;
  logic       rsp1_q, rsp1_d;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (arb_gnt)
  );

`ifdef ARRAY_PORT_ARBITER_CLEAR_EN
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Ports are only served while no sweep owns the array.
  assign arb_en         = (state_q == ST_IDLE);
  assign bus.clear_busy = (state_q == ST_CLEAR);

  // Sweep sequencing: start from index 0, leave after the last index; the counter wraps back to 0 on its own.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (bus.clear_start) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (&cnt_q) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Sweep state registers; reset aborts a sweep immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_clear;

  assign arb_en         = 1'b1;
  assign bus.clear_busy = 1'b0;
  assign unused_clear   = ^{bus.clear_start, CLEAR_VAL, ST_IDLE, ST_CLEAR};
`endif

  assign gnt            = arb_en ? arb_gnt : 2'b00;
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  // Memory port: the sweep, else the granted requester, else an idle read of index 0.
  always_comb begin
    bus.mem_wr_en  = 1'b0;
    bus.mem_index  = '0;
    bus.mem_wr_val = '0;
    if (gnt[0]) begin
      bus.mem_wr_en  = bus.req0_we;
      bus.mem_index  = bus.req0_index;
      bus.mem_wr_val = bus.req0_wdata;
    end else if (gnt[1]) begin
      bus.mem_wr_en  = bus.req1_we;
      bus.mem_index  = bus.req1_index;
      bus.mem_wr_val = bus.req1_wdata;
    end
`ifdef ARRAY_PORT_ARBITER_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      bus.mem_wr_en  = 1'b1;
      bus.mem_index  = cnt_q;
      bus.mem_wr_val = CLEAR_VAL;
    end
`endif
  end

  // Pointer hands priority to the other port after every grant; a read grant tags next cycle's data for its port.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
    rsp0_d = gnt[0] & ~bus.req0_we;
    rsp1_d = gnt[1] & ~bus.req1_we;
  end

  // Pointer and response-tag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
    end
  end

  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp_data   = bus.mem_rd_val;

endmodule
